axi_burst_mem_slave: RTL and testbench
======================================

AXI_BURST_MEM_SLAVE -- requirements
Module: axi_burst_mem_slave

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 32: AXI address width.
REQ-002 Parameter AXI_DATA_WIDTH, default 64: AXI data width; only 64 is supported.
REQ-003 Parameter AXI_ID_WIDTH, default 4: AXI ID width.
REQ-004 Parameter MEM_WORDS_LOG2, default 11: memory depth is 2^MEM_WORDS_LOG2 64-bit words (16 KiB).
REQ-005 Port clk, input, 1: single clock for all logic.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port axi_slave, AXI_BUS.Slave, parameterised as above: the AXI4 slave port consumed from the debug AXI master.
REQ-008 Port busy_o, output, 1: high whenever the block is not in IDLE.

Function
REQ-009 The FSM SHALL have the states IDLE, WDATA, WRESP and RDATA, with one outstanding transaction at a time.
REQ-010 In IDLE, aw_ready SHALL be 1 unless ar_valid=1 and read holds priority; ar_ready SHALL be 1 unless aw_valid=1 and write holds priority; in all other states both SHALL be 0.
REQ-011 Priority on simultaneous aw_valid/ar_valid SHALL alternate from the last granted type.
- After reset, write wins.
REQ-012 An AW handshake SHALL capture id, addr, len, size and burst, then enter WDATA on the next cycle with w_ready=1.
REQ-013 Each W handshake SHALL write the bytes enabled by w_strb to word addr[MEM_WORDS_LOG2+2:3] in the same cycle, then advance the address.
REQ-014 The beat counter SHALL end the write burst after beat len (beats numbered from 0), regardless of w_last.
- On that beat: WDATA -> WRESP.
REQ-015 A w_last value that does not match the final-beat position SHALL set b_resp=SLVERR (2'b10); otherwise b_resp=OKAY.
REQ-016 In WRESP, b_valid=1 and b_id=the captured AW id SHALL be held until b_ready.
- On the b_ready handshake: WRESP -> IDLE.
REQ-017 An AR handshake SHALL enter RDATA; r_valid SHALL rise exactly 1 cycle later (synchronous memory read).
REQ-018 While r_ready=1, reads SHALL sustain 1 beat per cycle.
- While r_ready=0, r_data, r_resp and r_last SHALL be held stable.
REQ-019 r_last SHALL be 1 on beat len only, and r_id SHALL equal the captured AR id.
- The handshake of the last beat: RDATA -> IDLE.
REQ-020 Next-address rules: FIXED (2'b00) holds the address; INCR (2'b01) adds 2^size; WRAP (2'b10) adds 2^size within the aligned (len+1)*2^size window; reserved (2'b11) behaves as INCR.
REQ-021 A WRAP with len+1 not in {2,4,8,16} SHALL be executed as INCR and SHALL return SLVERR on every beat/response.
REQ-022 A size greater than 3 SHALL be treated as size 3.
REQ-023 Address arithmetic SHALL be AXI_ADDR_WIDTH bits; overflow past 2^AXI_ADDR_WIDTH-1 wraps to 0.

Reset
REQ-024 Asserting rst_n low SHALL immediately force IDLE, with all valid and ready outputs 0 while reset is asserted, and r_data, b_resp, r_resp, r_id and b_id at 0.
- Write priority and busy_o SHALL also clear.
REQ-025 Reset mid-burst SHALL abandon the burst without a response; memory contents SHALL be retained, not cleared.
REQ-026 aw_ready/ar_ready SHALL first rise in the cycle after rst_n deasserts.

Configuration
REQ-027 With AXI_SLAVE_DECERR_EN defined, any beat addressing at or beyond 2^(MEM_WORDS_LOG2+3) bytes SHALL not write memory.
- Such beats return r_data=0 and DECERR (2'b11), which for writes is reported on b_resp.
REQ-028 Without AXI_SLAVE_DECERR_EN, addresses SHALL wrap modulo memory size and respond OKAY (subject to REQ-015/021).

Structure
REQ-029 Package axi_burst_pkg SHALL hold:
- the burst-type enum (FIXED/INCR/WRAP);
- resp constants (OKAY/SLVERR/DECERR);
- the FSM state enum.
REQ-030 Sub-module axi_burst_addr_gen SHALL compute next address from addr, size, len and burst, combinationally, and flag illegal WRAP.
REQ-031 The memory SHALL be an inferred byte-write-enable array inside axi_burst_mem_slave.

Verification
REQ-032 INCR write: AW addr=0x100, len=3, size=3; 4 beats of data 0xA0..0xA3, strb=0xFF, w_last on beat 3.
- Required: b_resp=OKAY.
- INCR read of the same range returns 0xA0..0xA3, with r_last on the 4th beat.
REQ-033 WRAP read: addr=0x118, len=3, size=3 returns words 0x118, 0x100, 0x108, 0x110 in order.
REQ-034 Simultaneous aw_valid and ar_valid held twice after reset.
- Required: write granted first, read second.
REQ-035 Write len=1 with w_last on beat 0.
- Required: 2 beats written; b_resp=SLVERR.
- Read with r_ready toggled 1,0,0,1: r_data stable while r_ready=0.
REQ-036 rst_n pulsed low during beat 2 of a len=7 read.
- Required: r_valid=0 immediately; ar_ready=1 the cycle after release; earlier-written data intact.
REQ-037 With AXI_SLAVE_DECERR_EN, a read at 0x4000 returns DECERR with r_data=0.
- Without the macro, the same read returns word 0x0000 with OKAY.

Source files
------------

// File: rtl/axi_burst_pkg.sv
// rtl/axi_burst_pkg.sv - shared burst, response and FSM types for the AXI burst memory slave
package axi_burst_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WDATA = 2'b01,
        ST_WRESP = 2'b10,
        ST_RDATA = 2'b11
    } state_e;

    // Beats wider than the 64-bit bus are executed as full 8-byte beats.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > 3'd3) ? 3'd3 : size;
    endfunction

endpackage

// File: rtl/axi_bus.sv
// rtl/axi_bus.sv - AXI4 bus bundle (address, data, response channels) with master/slave views
interface AXI_BUS #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic                        w_valid;
    logic                        w_ready;
    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic                        b_valid;
    logic                        b_ready;
    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_valid, input w_ready,
        input b_id, b_resp, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, input ar_ready,
        input r_id, r_data, r_resp, r_last, r_valid, output r_ready
    );

    modport Slave (
        input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, output aw_ready,
        input w_data, w_strb, w_last, w_valid, output w_ready,
        output b_id, b_resp, b_valid, input b_ready,
        input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid, input r_ready
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
    import axi_burst_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [2:0]                size,
    input  logic [7:0]                len,
    input  logic [1:0]                burst,
    output logic [AXI_ADDR_WIDTH-1:0] next_addr,
    output logic                      wrap_illegal
);
    localparam logic [AXI_ADDR_WIDTH-1:0] ONE = 1;

    logic [2:0]                sz;
    logic [AXI_ADDR_WIDTH-1:0] step;
    logic [AXI_ADDR_WIDTH-1:0] window_mask;
    logic [AXI_ADDR_WIDTH-1:0] incr_addr;
    logic                      wrap_ok;

    always_comb begin
        sz           = clamp_size(size);
        step         = ONE << sz;
        wrap_ok      = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        wrap_illegal = (burst == BURST_WRAP) && !wrap_ok;
        window_mask  = ((AXI_ADDR_WIDTH'(len) + ONE) << sz) - ONE;
        incr_addr    = addr + step;
        // Reserved burst type and illegal WRAP lengths fall through to INCR.
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if ((burst == BURST_WRAP) && wrap_ok) begin
            next_addr = (addr & ~window_mask) | (incr_addr & window_mask);
        end else begin
            next_addr = incr_addr;
        end
    end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// rtl/axi_burst_mem_slave.sv - single-outstanding AXI4 burst slave over a byte-enable memory
// Define AXI_SLAVE_DECERR_EN to reject beats beyond the memory with DECERR instead of aliasing.
module axi_burst_mem_slave
    import axi_burst_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_WORDS_LOG2 = 11
) (
    input  logic  clk,
    input  logic  rst_n,
    AXI_BUS.Slave axi_slave,
    output logic  busy_o
);
    localparam int AW    = AXI_ADDR_WIDTH;
    localparam int MW    = MEM_WORDS_LOG2;
    localparam int DEPTH = 1 << MW;
    localparam int STRBS = AXI_DATA_WIDTH / 8;

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    state_e                    state;
    logic                      accept;
    logic                      prio_read;
    logic [AXI_ID_WIDTH-1:0]   cur_id;
    logic [AW-1:0]             cur_addr;
    logic [7:0]                cur_len;
    logic [2:0]                cur_size;
    logic [1:0]                cur_burst;
    logic [7:0]                beat;
    logic                      err;
    logic                      w_ready;
    logic                      b_valid;
    logic [1:0]                b_resp;
    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic                      r_valid;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_ID_WIDTH-1:0]   r_id;

    logic                      aw_ready, ar_ready, aw_hs, ar_hs, w_hs, w_final, wr_en;
    logic [AW-1:0]             g_addr, next_addr;
    logic [2:0]                g_size;
    logic [7:0]                g_len;
    logic [1:0]                g_burst;
    logic                      wrap_illegal;
    logic [MW-1:0]             rd_idx, wr_idx;
    logic [AXI_DATA_WIDTH-1:0] rd_word;
    logic [1:0]                rd_resp, wr_resp;
    logic                      rd_err, wr_bad;
`ifdef AXI_SLAVE_DECERR_EN
    logic                      dec_err, rd_oor, wr_oor;
`endif

    axi_burst_addr_gen #(.AXI_ADDR_WIDTH(AW)) u_addr_gen (
        .addr        (g_addr),
        .size        (g_size),
        .len         (g_len),
        .burst       (g_burst),
        .next_addr   (next_addr),
        .wrap_illegal(wrap_illegal)
    );

    always_comb begin
        aw_ready = accept && !(axi_slave.ar_valid && prio_read);
        ar_ready = accept && !(axi_slave.aw_valid && !prio_read);
        aw_hs    = axi_slave.aw_valid && aw_ready;
        ar_hs    = axi_slave.ar_valid && ar_ready;
        w_hs     = axi_slave.w_valid && w_ready;
        w_final  = (beat == cur_len);
        // While idle the generator looks at the incoming request so its WRAP check is ready at handshake.
        if (accept) begin
            g_addr  = aw_hs ? axi_slave.aw_addr  : axi_slave.ar_addr;
            g_size  = aw_hs ? axi_slave.aw_size  : axi_slave.ar_size;
            g_len   = aw_hs ? axi_slave.aw_len   : axi_slave.ar_len;
            g_burst = aw_hs ? axi_slave.aw_burst : axi_slave.ar_burst;
        end else begin
            g_addr  = cur_addr;
            g_size  = cur_size;
            g_len   = cur_len;
            g_burst = cur_burst;
        end
        rd_idx  = ar_hs ? axi_slave.ar_addr[MW+2:3] : next_addr[MW+2:3];
        wr_idx  = cur_addr[MW+2:3];
        rd_err  = ar_hs ? wrap_illegal : err;
        wr_bad  = err || (axi_slave.w_last != w_final);
`ifdef AXI_SLAVE_DECERR_EN
        rd_oor  = ((ar_hs ? axi_slave.ar_addr : next_addr) >> (MW + 3)) != '0;
        wr_oor  = (cur_addr >> (MW + 3)) != '0;
        wr_en   = w_hs && !wr_oor;
        rd_word = rd_oor ? '0 : mem[rd_idx];
        rd_resp = rd_oor ? RESP_DECERR : (rd_err ? RESP_SLVERR : RESP_OKAY);
        wr_resp = (dec_err || wr_oor) ? RESP_DECERR : (wr_bad ? RESP_SLVERR : RESP_OKAY);
`else
        wr_en   = w_hs;
        rd_word = mem[rd_idx];
        rd_resp = rd_err ? RESP_SLVERR : RESP_OKAY;
        wr_resp = wr_bad ? RESP_SLVERR : RESP_OKAY;
`endif
    end

    // Memory has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRBS; i++) begin
            if (wr_en && axi_slave.w_strb[i]) begin
                mem[wr_idx][8*i +: 8] <= axi_slave.w_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            accept    <= 1'b0;
            prio_read <= 1'b0;
            cur_id    <= '0;
            cur_addr  <= '0;
            cur_len   <= '0;
            cur_size  <= '0;
            cur_burst <= '0;
            beat      <= '0;
            err       <= 1'b0;
            w_ready   <= 1'b0;
            b_valid   <= 1'b0;
            b_resp    <= '0;
            b_id      <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_resp    <= '0;
            r_last    <= 1'b0;
            r_id      <= '0;
`ifdef AXI_SLAVE_DECERR_EN
            dec_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        state     <= ST_WDATA;
                        accept    <= 1'b0;
                        prio_read <= 1'b1;
                        cur_id    <= axi_slave.aw_id;
                        cur_addr  <= axi_slave.aw_addr;
                        cur_len   <= axi_slave.aw_len;
                        cur_size  <= axi_slave.aw_size;
                        cur_burst <= axi_slave.aw_burst;
                        beat      <= '0;
                        err       <= wrap_illegal;
                        w_ready   <= 1'b1;
`ifdef AXI_SLAVE_DECERR_EN
                        dec_err   <= 1'b0;
`endif
                    end else if (ar_hs) begin
                        state     <= ST_RDATA;
                        accept    <= 1'b0;
                        prio_read <= 1'b0;
                        cur_id    <= axi_slave.ar_id;
                        cur_addr  <= axi_slave.ar_addr;
                        cur_len   <= axi_slave.ar_len;
                        cur_size  <= axi_slave.ar_size;
                        cur_burst <= axi_slave.ar_burst;
                        beat      <= '0;
                        err       <= wrap_illegal;
                        r_valid   <= 1'b1;
                        r_data    <= rd_word;
                        r_resp    <= rd_resp;
                        r_last    <= (axi_slave.ar_len == 8'd0);
                        r_id      <= axi_slave.ar_id;
                    end else begin
                        accept    <= 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (w_hs) begin
                        cur_addr <= next_addr;
                        beat     <= beat + 8'd1;
                        err      <= wr_bad;
`ifdef AXI_SLAVE_DECERR_EN
                        dec_err  <= dec_err || wr_oor;
`endif
                        if (w_final) begin
                            state   <= ST_WRESP;
                            w_ready <= 1'b0;
                            b_valid <= 1'b1;
                            b_resp  <= wr_resp;
                            b_id    <= cur_id;
                        end
                    end
                end
                ST_WRESP: begin
                    if (axi_slave.b_ready) begin
                        state   <= ST_IDLE;
                        accept  <= 1'b1;
                        b_valid <= 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (r_valid && axi_slave.r_ready) begin
                        if (r_last) begin
                            state   <= ST_IDLE;
                            accept  <= 1'b1;
                            r_valid <= 1'b0;
                        end else begin
                            cur_addr <= next_addr;
                            beat     <= beat + 8'd1;
                            r_data   <= rd_word;
                            r_resp   <= rd_resp;
                            r_last   <= ((beat + 8'd1) == cur_len);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign axi_slave.aw_ready = aw_ready;
    assign axi_slave.ar_ready = ar_ready;
    assign axi_slave.w_ready  = w_ready;
    assign axi_slave.b_valid  = b_valid;
    assign axi_slave.b_resp   = b_resp;
    assign axi_slave.b_id     = b_id;
    assign axi_slave.r_valid  = r_valid;
    assign axi_slave.r_data   = r_data;
    assign axi_slave.r_resp   = r_resp;
    assign axi_slave.r_last   = r_last;
    assign axi_slave.r_id     = r_id;
    assign busy_o             = (state != ST_IDLE);

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// tb/tb_axi_burst_mem_slave.sv - randomized self-checking bench with a byte-level memory model
module tb_axi_burst_mem_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
`ifdef AXI_SLAVE_DECERR_EN
    localparam bit DECERR_BUILD = 1'b1;
`else
    localparam bit DECERR_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [63:0] ref_mem   [2048];
    logic [7:0]  ref_known [2048];

    logic [31:0] cw_addr, cr_addr;
    logic [7:0]  cw_len, cr_len;
    logic [2:0]  cw_size, cr_size;
    logic [1:0]  cw_burst, cr_burst;
    logic [3:0]  cw_id, cr_id;
    int          cw_last;
    bit          cw_dec;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4)) bus ();

    axi_burst_mem_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .axi_slave(bus),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit wrap_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic bit is_oor(input logic [31:0] a);
        return DECERR_BUILD && (a >= 32'h4000);
    endfunction

    // Address of beat i computed directly from the start address, not iteratively.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst, input int i);
        logic [31:0] bytes, win, lower;
        bytes = 32'd1 << ((size > 3'd3) ? 3'd3 : size);
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && wrap_ok(len)) begin
            win   = (32'(len) + 32'd1) * bytes;
            lower = a - (a % win);
            return lower + (((a - lower) + 32'(i) * bytes) % win);
        end
        return a + 32'(i) * bytes;
    endfunction

    task automatic aw_go(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
        int t;
        cw_addr = a; cw_len = len; cw_size = size; cw_burst = burst; cw_id = id; cw_dec = 0;
        bus.aw_addr = a; bus.aw_len = len; bus.aw_size = size; bus.aw_burst = burst; bus.aw_id = id;
        bus.aw_valid = 1'b1;
        #1;
        t = 0;
        while (!bus.aw_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("aw_timeout", 0, 1);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        chk("w_ready_after_aw", bus.w_ready, 1);
    endtask

    task automatic w_go(input int last_beat, input bit fixed, input logic [63:0] base, input bit full);
        int t;
        logic [63:0] d;
        logic [7:0]  s;
        logic [31:0] a;
        logic [10:0] idx;
        cw_last = last_beat;
        for (int i = 0; i <= int'(cw_len); i++) begin
            if (!fixed && $urandom_range(3) == 0) begin
                bus.w_valid = 1'b0;
                @(posedge clk); #1;
            end
            d = fixed ? base + 64'(i) : {$urandom, $urandom};
            s = full ? 8'hFF : 8'($urandom_range(255));
            bus.w_data = d; bus.w_strb = s; bus.w_last = (i == last_beat); bus.w_valid = 1'b1;
            #1;
            t = 0;
            while (!bus.w_ready && t < 200) begin @(negedge clk); t++; end
            if (t >= 200) chk("w_timeout", 0, 1);
            @(posedge clk); #1;
            a = beat_addr(cw_addr, cw_len, cw_size, cw_burst, i);
            if (is_oor(a)) begin
                cw_dec = 1;
            end else begin
                idx = a[13:3];
                for (int b = 0; b < 8; b++)
                    if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                ref_known[idx] = ref_known[idx] | s;
            end
        end
        bus.w_valid = 1'b0;
        bus.w_last = 1'b0;
    endtask

    task automatic b_go();
        int t;
        logic [1:0] exp;
        if (cw_dec) exp = DECERR;
        else if ((cw_last != int'(cw_len)) || (cw_burst == 2'b10 && !wrap_ok(cw_len))) exp = SLVERR;
        else exp = OKAY;
        t = 0;
        while (!bus.b_valid && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("b_timeout", 0, 1);
        repeat ($urandom_range(2)) @(posedge clk);
        #1;
        chk("b_resp", bus.b_resp, exp);
        chk("b_id", bus.b_id, cw_id);
        chk("busy_wresp", busy, 1);
        bus.b_ready = 1'b1;
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
        chk("busy_after_b", busy, 0);
    endtask

    task automatic ar_go(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
        int t;
        cr_addr = a; cr_len = len; cr_size = size; cr_burst = burst; cr_id = id;
        bus.ar_addr = a; bus.ar_len = len; bus.ar_size = size; bus.ar_burst = burst; bus.ar_id = id;
        bus.ar_valid = 1'b1;
        #1;
        t = 0;
        while (!bus.ar_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("ar_timeout", 0, 1);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        chk("r_valid_latency", bus.r_valid, 1);
    endtask

    task automatic r_go(input bit use_pat, input logic [15:0] pat);
        int i, cyc;
        logic rr, rv;
        logic [31:0] a;
        logic [10:0] idx;
        logic [63:0] mask, exp_d;
        logic [1:0]  exp_r;
        i = 0; cyc = 0;
        while (i <= int'(cr_len) && cyc < 400) begin
            bus.r_ready = use_pat ? ((cyc < 16) ? pat[cyc] : 1'b1) : ($urandom_range(3) != 0);
            @(negedge clk);
            a = beat_addr(cr_addr, cr_len, cr_size, cr_burst, i);
            if (is_oor(a)) begin
                mask = '1; exp_d = '0; exp_r = DECERR;
            end else begin
                idx = a[13:3];
                for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{ref_known[idx][b]}};
                exp_d = ref_mem[idx] & mask;
                exp_r = (cr_burst == 2'b10 && !wrap_ok(cr_len)) ? SLVERR : OKAY;
            end
            rv = bus.r_valid;
            rr = bus.r_ready;
            chk("r_valid", rv, 1);
            chk("r_data", bus.r_data & mask, exp_d);
            chk("r_resp", bus.r_resp, exp_r);
            chk("r_last", bus.r_last, (i == int'(cr_len)));
            chk("r_id", bus.r_id, cr_id);
            @(posedge clk);
            if (rr && rv) i++;
            #1;
            cyc++;
        end
        bus.r_ready = 1'b0;
        if (cyc >= 400) chk("r_timeout", 0, 1);
        chk("r_valid_done", bus.r_valid, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  len;
        int          last;
        for (int k = 0; k < 2048; k++) begin ref_mem[k] = '0; ref_known[k] = '0; end
        bus.aw_valid = 0; bus.w_valid = 0; bus.b_ready = 0; bus.ar_valid = 0; bus.r_ready = 0;
        bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0; bus.aw_size = 0; bus.aw_burst = 0;
        bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0; bus.ar_size = 0; bus.ar_burst = 0;
        bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_aw_ready", bus.aw_ready, 0);
        chk("rst_ar_ready", bus.ar_ready, 0);
        chk("rst_w_ready", bus.w_ready, 0);
        chk("rst_b_valid", bus.b_valid, 0);
        chk("rst_r_valid", bus.r_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_r_data", bus.r_data, 0);
        chk("rst_resp", {bus.b_resp, bus.r_resp}, 0);
        chk("rst_ids", {bus.b_id, bus.r_id}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_release_cycle", bus.aw_ready, 0);
        @(posedge clk); #1;
        chk("aw_ready_after_release", bus.aw_ready, 1);
        chk("ar_ready_after_release", bus.ar_ready, 1);

        // Simultaneous requests: write first after reset, then read.
        bus.aw_addr = 32'h0; bus.aw_len = 0; bus.aw_size = 3; bus.aw_burst = 1; bus.aw_id = 4'h1;
        bus.ar_addr = 32'h0; bus.ar_len = 0; bus.ar_size = 3; bus.ar_burst = 1; bus.ar_id = 4'h2;
        bus.aw_valid = 1'b1; bus.ar_valid = 1'b1;
        @(negedge clk);
        chk("prio_first_aw", bus.aw_ready, 1);
        chk("prio_first_ar", bus.ar_ready, 0);
        aw_go(32'h0, 0, 3, 2'b01, 4'h1);
        w_go(0, 0, 0, 1);
        b_go();
        bus.aw_addr = 32'h8; bus.aw_len = 0; bus.aw_size = 3; bus.aw_burst = 1; bus.aw_id = 4'h3;
        bus.aw_valid = 1'b1;
        @(negedge clk);
        chk("prio_second_aw", bus.aw_ready, 0);
        chk("prio_second_ar", bus.ar_ready, 1);
        ar_go(32'h0, 0, 3, 2'b01, 4'h2);
        r_go(0, 0);
        aw_go(32'h8, 0, 3, 2'b01, 4'h3);
        w_go(0, 0, 0, 1);
        b_go();

        // INCR write/read of 0xA0..0xA3, then WRAP read starting mid-window.
        aw_go(32'h100, 3, 3, 2'b01, 4'h5);
        w_go(3, 1, 64'hA0, 1);
        b_go();
        ar_go(32'h100, 3, 3, 2'b01, 4'h6);
        r_go(0, 0);
        ar_go(32'h118, 3, 3, 2'b10, 4'h7);
        r_go(1, 16'hFFFF);

        // Early w_last, then read with a stalled r_ready.
        aw_go(32'h300, 1, 3, 2'b01, 4'h8);
        w_go(0, 0, 0, 1);
        b_go();
        ar_go(32'h300, 1, 3, 2'b01, 4'h9);
        r_go(1, 16'b1111_1111_1111_1001);

        // Reset mid-read must drop the burst but keep memory.
        aw_go(32'h200, 7, 3, 2'b01, 4'hA);
        w_go(7, 0, 0, 1);
        b_go();
        ar_go(32'h200, 7, 3, 2'b01, 4'hB);
        bus.r_ready = 1'b1;
        @(posedge clk); @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_r_valid", bus.r_valid, 0);
        chk("midrst_ar_ready", bus.ar_ready, 0);
        chk("midrst_busy", busy, 0);
        bus.r_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ar_ready_after_midrst", bus.ar_ready, 1);
        ar_go(32'h200, 7, 3, 2'b01, 4'hC);
        r_go(0, 0);

        ar_go(32'h4000, 0, 3, 2'b01, 4'hD);
        r_go(0, 0);

        for (int n = 0; n < 40; n++) begin
            a   = $urandom_range(32'h7FFF);
            if ($urandom_range(7) == 0) a = 32'hFFFF_FFC0 + 32'($urandom_range(63));
            len = 8'($urandom_range(15));
            last = ($urandom_range(3) == 0) ? $urandom_range(15) : int'(len);
            aw_go(a, len, 3'($urandom_range(7)), 2'($urandom_range(3)), 4'($urandom_range(15)));
            w_go(last, 0, 0, 0);
            b_go();
            if ($urandom_range(1) == 0) begin
                ar_go(cw_addr, cw_len, cw_size, cw_burst, 4'($urandom_range(15)));
            end else begin
                ar_go($urandom_range(32'h7FFF), 8'($urandom_range(15)), 3'($urandom_range(7)),
                      2'($urandom_range(3)), 4'($urandom_range(15)));
            end
            r_go(0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
